uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter: OVS, 16, oversample ticks per bit (even, 8..64).
REQ-002 SHALL have port: clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: tick  in  1  one-clk oversample strobe, OVS per bit period.
REQ-005 SHALL have port: rx  in  1  raw asynchronous serial line, idle high.
REQ-006 SHALL have port: sample  out  1  one-clk strobe to the 8-bit shift datapath at each data-bit mid-point.
REQ-007 SHALL have port: shift_clr  out  1  one-clk strobe clearing the datapath bit index and register.
REQ-008 SHALL have port: shift_data  in  8  parallel byte from the shift datapath, LSB first received.
REQ-009 SHALL have port: rx_data  out  8  holding register.
REQ-010 SHALL have port: rx_valid  out  1  holding register full.
REQ-011 SHALL have port: rx_ready  in  1  consumer accepts rx_data when rx_valid and rx_ready are both high.
REQ-012 SHALL have port: frame_err  out  1  sticky: stop bit sampled low.
REQ-013 SHALL have port: overrun_err  out  1  sticky: byte completed while holding register full.
REQ-014 SHALL have port: parity_err  out  1  sticky: parity mismatch (REQ-031).
REQ-015 SHALL have port: err_clr  in  1  one-clk clear of all sticky errors.

Function
REQ-016 SHALL drive rx through a 2-flop synchronizer, preset high, to give rx_s; all decisions use rx_s.
REQ-017 SHALL implement FSM states IDLE, START, DATA, [PARITY], STOP, BREAK; a tick counter advances only on tick.
REQ-018 IDLE: on tick with rx_s=0 SHALL go to START with counter=0.
REQ-019 START: at counter OVS/2-1 on tick, rx_s=0 SHALL go to DATA with counter=0 and bit count=0 and pulse shift_clr; rx_s=1 (glitch) SHALL go to IDLE without any strobe.
REQ-020 DATA: at counter OVS-1 on tick SHALL pulse sample coincident with that tick, reset counter, and increment bit count; after the 8th sample SHALL go to STOP, or PARITY when enabled.
REQ-021 STOP: at counter OVS-1 on tick, rx_s=1 SHALL complete the byte (REQ-023); rx_s=0 SHALL set frame_err, discard the byte, and go to BREAK.
REQ-022 BREAK: SHALL stay until a tick with rx_s=1, then go to IDLE.
REQ-023 On completion SHALL go to IDLE; on the next clk SHALL load rx_data from shift_data and set rx_valid. Latency is one clk after the stop-bit mid-point tick.
REQ-024 rx_valid SHALL clear on the clk after rx_valid&&rx_ready.
REQ-025 Completion with rx_valid=1 and rx_ready=0 SHALL set overrun_err, keep old rx_data, and drop the new byte.
REQ-026 Completion in the same clk as a handshake SHALL load the new byte, keep rx_valid=1, and not flag overrun.
REQ-027 err_clr SHALL clear all sticky errors; an error event in the same clk SHALL win and leave the flag set.
REQ-028 At most one sample or shift_clr SHALL be high in any clk; neither SHALL occur outside DATA/START.

Reset
REQ-029 rst SHALL force state=IDLE, counters=0, synchronizer=1, sample=0, shift_clr=0, rx_data=0x00, rx_valid=0, and all errors=0 on the next edge, including mid-frame.
REQ-030 After reset SHALL require a fresh falling edge; a line already low SHALL be treated as a start bit on the first tick.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: SHALL add a PARITY state after DATA that samples at counter OVS-1. It SHALL compare rx_s with the even parity of shift_data, set parity_err on mismatch, and still deliver the byte.
REQ-032 Macro UART_RX_PARITY_EN undefined: SHALL have no PARITY state, go DATA->STOP, and tie parity_err to 0.

Verification
REQ-033 Frame 0xA5 (8N1), OVS=16, rx_ready=1 -> exactly 8 sample pulses, then rx_data=0xA5 and rx_valid=1 for one clk; no errors.
REQ-034 rx low for 4 ticks, then high -> no shift_clr or sample, FSM returns to IDLE, rx_valid=0.
REQ-035 Frame 0x3C with stop bit low -> frame_err=1, rx_valid=0; the following good frame 0x11 -> rx_data=0x11.
REQ-036 Frames 0x01 then 0x02 with rx_ready=0 -> rx_data=0x01, overrun_err=1; err_clr -> overrun_err=0.
REQ-037 PARITY_EN, frame 0x07 with parity bit 0 -> parity_err=1 and rx_data=0x07; with parity bit 1 -> parity_err=0.
REQ-038 rst asserted during DATA bit 4 -> next clk all outputs at reset values; the next frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- UART receive controller (8 data bits, 1 stop bit, optional
// even parity). Oversampled framing FSM that drives an external 8-bit shift
// datapath and owns the holding register and the sticky error flags.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> a PARITY bit follows the data bits and is checked for even
//                parity against shift_data
//   undefined -> DATA goes straight to STOP and parity_err is tied low
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   tick         one-clk oversample strobe, OVS per bit period
//   rx           raw asynchronous serial line, idle high
//   sample       one-clk strobe to the datapath at each data-bit mid-point
//   shift_clr    one-clk strobe clearing the datapath bit index and register
//   shift_data   parallel byte from the datapath (LSB received first)
//   rx_data      holding register
//   rx_valid     holding register full
//   rx_ready     consumer ready
//   frame_err    sticky: stop bit sampled low
//   overrun_err  sticky: byte completed while holding register full
//   parity_err   sticky: parity mismatch
//   err_clr      one-clk clear of all sticky errors
//   fsm_state    debug view of the FSM state
//                (0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 BREAK)
//
// Handshake: rx_data is transferred on every clk edge where rx_valid and
// rx_ready are both high; rx_valid then drops on that edge unless a new
// byte completes in the same clk, in which case the new byte is loaded and
// rx_valid stays high. rx_data is stable while rx_valid is high.
module uart_rx_ctrl #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       rx,
  output logic       sample,
  output logic       shift_clr,
  input  logic [7:0] shift_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err,
  input  logic       err_clr,
  output logic [2:0] fsm_state
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] CNT_MID = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic          complete;
  logic          done_q;
  logic          frame_evt;
  logic          overrun_evt;
`ifdef UART_RX_PARITY_EN
  logic          parity_evt;
`endif

  assign rx_s      = sync_q[1];
  assign fsm_state = state;

  // Next-state and strobes. Everything is qualified by tick, so the counter
  // only advances at the oversample rate. Strobes are suppressed during rst.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    sample      = 1'b0;
    shift_clr   = 1'b0;
    complete    = 1'b0;
    frame_evt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_evt  = 1'b0;
`endif
    if (tick && !rst) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            cnt_nxt   = '0;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt_nxt = '0;
            if (!rx_s) begin
              state_nxt   = DATA;
              bit_cnt_nxt = 3'd0;
              shift_clr   = 1'b1;
            end else begin
              state_nxt = IDLE;  // glitch: line back high at start mid-point
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_END) begin
            sample      = 1'b1;
            cnt_nxt     = '0;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_nxt = AFTER_DATA;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_END) begin
            // Even parity: the parity bit equals the XOR of the data bits.
            parity_evt = (rx_s != ^shift_data);
            cnt_nxt    = '0;
            state_nxt  = STOP;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_END) begin
            cnt_nxt = '0;
            if (rx_s) begin
              complete  = 1'b1;
              state_nxt = IDLE;
            end else begin
              frame_evt = 1'b1;
              state_nxt = BREAK;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        BREAK: begin
          if (rx_s) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      done_q  <= complete;  // holding register loads one clk after completion
    end
  end

  assign overrun_evt = done_q && rx_valid && !rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else if (done_q && (!rx_valid || rx_ready)) begin
      rx_data  <= shift_data;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // Sticky flags: a new error event in the same clk as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_evt   | (frame_err   & ~err_clr);
      overrun_err <= overrun_evt | (overrun_err & ~err_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= parity_evt | (parity_err & ~err_clr);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int OVS  = 16;
  localparam int TDIV = 4;  // clks per oversample tick

  // ---------------- clock / reset / tick ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic       err_clr = 1'b0;
  logic       sample, shift_clr, rx_valid;
  logic       frame_err, overrun_err, parity_err;
  logic [7:0] shift_data, rx_data;
  logic [2:0] fsm_state;
  int         div = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div  <= (div == TDIV - 1) ? 0 : div + 1;
    tick <= (div == TDIV - 2);
  end

  // External 8-bit shift datapath: LSB first.
  logic [7:0] sreg = 8'h00;
  always @(posedge clk) begin
    if (shift_clr)   sreg <= 8'h00;
    else if (sample) sreg <= {rx, sreg[7:1]};
  end
  assign shift_data = sreg;

  uart_rx_ctrl #(.OVS(OVS)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .rx          (rx),
    .sample      (sample),
    .shift_clr   (shift_clr),
    .shift_data  (shift_data),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .err_clr     (err_clr),
    .fsm_state   (fsm_state)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  int sample_cnt = 0, clr_cnt = 0, valid_clks = 0, both_cnt = 0;

  always @(negedge clk) begin
    if (sample)              sample_cnt++;
    if (shift_clr)           clr_cnt++;
    if (sample && shift_clr) both_cnt++;
    if (rx_valid)            valid_clks++;
    if (rx_valid && rx_ready) begin
      check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rx_data_pop", rx_data, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx = b;
    wait_ticks(OVS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    wait_ticks(1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`else
    if (par_b === 1'bx) $display("note: parity bit unknown");
`endif
    drive_bit(stop_b);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(4);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic reset_counters();
    settle();
    sample_cnt = 0;
    clr_cnt    = 0;
    valid_clks = 0;
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1;
    rx_ready = r;
  endtask

  task automatic send_good(input logic [7:0] d);
    exp_q.push_back(d);
    send_frame(d, 1'b1, ^d);
    drain();
    check("rx_data_hold", rx_data, d);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [7:0] b;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rx_valid",   rx_valid,    0);
    check("rst_rx_data",    rx_data,     0);
    check("rst_frame_err",  frame_err,   0);
    check("rst_overrun",    overrun_err, 0);
    check("rst_parity",     parity_err,  0);
    check("rst_sample",     sample,      0);
    check("rst_shift_clr",  shift_clr,   0);
    check("rst_state",      fsm_state,   0);
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(4);

    // Good frame 0xA5 with rx_ready high.
    reset_counters();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0 ^ 1'b0 ^ 1'b0 ^ 1'b0);  // 0xA5 has four ones
    settle();
    check("a5_samples",    sample_cnt, 8);
    check("a5_clr",        clr_cnt,    1);
    check("a5_valid_clks", valid_clks, 1);
    check("a5_frame_err",  frame_err,  0);
    check("a5_overrun",    overrun_err, 0);
    check("a5_parity",     parity_err, 0);
    drain();

    // Start-bit glitch: low for 4 ticks then high.
    reset_counters();
    wait_ticks(1);
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(OVS);
    settle();
    check("glitch_samples", sample_cnt, 0);
    check("glitch_clr",     clr_cnt,    0);
    check("glitch_state",   fsm_state,  0);
    check("glitch_valid",   rx_valid,   0);

    // Framing error on 0x3C, then a good 0x11.
    reset_counters();
    send_frame(8'h3C, 1'b0, 1'b0);
    settle();
    check("ferr_flag",   frame_err,  1);
    check("ferr_valid",  rx_valid,   0);
    check("ferr_vclks",  valid_clks, 0);
    send_good(8'h11);
    check("ferr_sticky", frame_err,  1);
    pulse_err_clr();
    check("ferr_clr",    frame_err,  0);

    // Overrun: 0x01 then 0x02 with rx_ready low.
    set_ready(1'b0);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h02, 1'b1, 1'b1);
    settle();
    check("ovr_data",  rx_data,     8'h01);
    check("ovr_valid", rx_valid,    1);
    check("ovr_flag",  overrun_err, 1);
    pulse_err_clr();
    check("ovr_clr",   overrun_err, 0);
    set_ready(1'b1);
    drain();

    // Random bytes.
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      send_good(b);
    end

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1.
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    drain();
    check("par_bad_flag", parity_err, 1);
    check("par_bad_data", rx_data,    8'h07);
    pulse_err_clr();
    check("par_clr",      parity_err, 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    drain();
    check("par_ok_flag",  parity_err, 0);
    check("par_ok_data",  rx_data,    8'h07);
`else
    check("par_tied", parity_err, 0);
`endif

    // Reset in the middle of data bit 4, with non-reset state beforehand.
    send_frame(8'h3C, 1'b0, 1'b0);
    send_good(8'hC3);
    check("pre_rst_ferr", frame_err, 1);
    b = 8'hE7;
    wait_ticks(1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    @(negedge clk);
    rx = b[4];
    wait_ticks(OVS / 2);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    settle();
    check("mid_rst_data",   rx_data,     0);
    check("mid_rst_valid",  rx_valid,    0);
    check("mid_rst_ferr",   frame_err,   0);
    check("mid_rst_ovr",    overrun_err, 0);
    check("mid_rst_par",    parity_err,  0);
    check("mid_rst_sample", sample,      0);
    check("mid_rst_clr",    shift_clr,   0);
    check("mid_rst_state",  fsm_state,   0);
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(OVS);
    reset_counters();
    send_good(8'h5A);
    check("post_rst_samples", sample_cnt, 8);

    settle();
    check("strobe_excl", both_cnt, 0);
    check("final_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
